mem_port_arbiter: RTL

//  Shares one unified memory port between instruction fetch (IF) and load/store (LS).

---
 rtl/mem_arb_pkg.sv | 5 +
 rtl/arb_prio_pick.sv | 26 ++
 rtl/mem_port_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state and owner encodings for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;
    typedef enum logic {OWN_IF, OWN_LS} arb_owner_t;
endpackage

// File: rtl/arb_prio_pick.sv
// arb_prio_pick: LS-priority winner selection with an IF anti-starvation streak limit
module arb_prio_pick #(
    parameter int MAX_LS_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic ls_req,
    input  logic pick_en,
    output logic win_if,
    output logic win_ls
);
    localparam int SW = $clog2(MAX_LS_STREAK + 1);
    localparam logic [SW-1:0] MAX_S = SW'(MAX_LS_STREAK);
    logic [SW-1:0] streak_q, streak_d;
    always_comb begin
        win_ls   = pick_en && ls_req && !(if_req && streak_q == MAX_S);
        win_if   = pick_en && if_req && !win_ls;
        streak_d = (win_if || (pick_en && !if_req)) ? '0
                 : (win_ls && streak_q != MAX_S) ? streak_q + SW'(1) : streak_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) streak_q <= '0;
        else        streak_q <= streak_d;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one transaction in flight
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [DW/8-1:0] ls_be,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [DW-1:0]   ls_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);
    arb_state_t      state_q, state_d;
    arb_owner_t      owner_q, owner_d;
    logic            mem_we_q, mem_we_d;
    logic [DW/8-1:0] mem_be_q, mem_be_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            pick_en, win_if, win_ls, rsp;

    arb_prio_pick #(.MAX_LS_STREAK(MAX_LS_STREAK)) u_pick (
        .clk     (clk),
        .reset   (reset),
        .if_req  (if_req),
        .ls_req  (ls_req),
        .pick_en (pick_en),
        .win_if  (win_if),
        .win_ls  (win_ls)
    );

    always_comb begin
        pick_en     = reset && state_q == ARB_IDLE;
        rsp         = reset && state_q == ARB_WAIT && mem_rvalid;
        state_d     = (win_if || win_ls) ? ARB_ISSUE
                    : (state_q == ARB_ISSUE && mem_gnt) ? ARB_WAIT
                    : rsp ? ARB_IDLE : state_q;
        owner_d     = win_ls ? OWN_LS : win_if ? OWN_IF : owner_q;
        mem_we_d    = win_ls ? ls_we : win_if ? 1'b0 : mem_we_q;
        mem_be_d    = win_ls ? ls_be : win_if ? '1 : mem_be_q;
        mem_addr_d  = win_ls ? ls_addr : win_if ? if_addr : mem_addr_q;
        mem_wdata_d = win_ls ? ls_wdata : win_if ? '0 : mem_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IF;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_gnt    = win_if;
    assign ls_gnt    = win_ls;
    assign if_rvalid = rsp && owner_q == OWN_IF;
    assign ls_rvalid = rsp && owner_q == OWN_LS;
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;
    assign mem_req   = state_q == ARB_ISSUE;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = state_q != ARB_IDLE;
endmodule
